// File: rtl/memory_hs.sv
// Single-port synchronous memory behind a req/ack handshake.
// Supports wait states, byte-lane writes and an out-of-range error response.
module memory_hs #(
  parameter int AWIDTH      = 5,
  parameter int DWIDTH      = 8,
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [AWIDTH-1:0]     addr,
  input  logic [DWIDTH/8-1:0]   be,
  input  logic [DWIDTH-1:0]     wdata,
  output logic [DWIDTH-1:0]     rdata,
  output logic                  ack,
  output logic                  err,
  output logic                  busy
);

  localparam int NB = DWIDTH / 8;
  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH + 1)'(DEPTH);
  localparam logic [3:0] WS_W = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic              we_q;
  logic [AWIDTH-1:0] addr_q;
  logic [NB-1:0]     be_q;
  logic [DWIDTH-1:0] wdata_q;

  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic ack_q, ack_d;
  logic err_q, err_d;
  logic busy_q, busy_d;

  logic [DWIDTH-1:0] mem [DEPTH];

  logic              acc;
  logic              acc_we;
  logic [AWIDTH-1:0] acc_addr;
  logic [NB-1:0]     acc_be;
  logic [DWIDTH-1:0] acc_wdata;
  logic              in_range;

  // With no wait states the access happens on the capture edge,
  // so the live inputs are used instead of the holding registers.
  assign acc_we    = (WAIT_STATES == 0) ? we    : we_q;
  assign acc_addr  = (WAIT_STATES == 0) ? addr  : addr_q;
  assign acc_be    = (WAIT_STATES == 0) ? be    : be_q;
  assign acc_wdata = (WAIT_STATES == 0) ? wdata : wdata_q;
  assign in_range  = {1'b0, acc_addr} < DEPTH_W;

  // Next-state, access strobe and registered-output next values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc     = 1'b0;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            acc     = 1'b1;
            state_d = ACK;
          end else begin
            cnt_d   = WS_W;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          acc     = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (acc) begin
      ack_d = 1'b1;
      err_d = ~in_range;
      if (in_range && !acc_we) begin
        rdata_d = mem[acc_addr];
      end
    end
    busy_d = (state_d != IDLE);
  end

  // State, counter, holding registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req) begin
        we_q    <= we;
        addr_q  <= addr;
        be_q    <= be;
        wdata_q <= wdata;
      end
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Array write; contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (acc && acc_we && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (acc_be[i]) begin
          mem[acc_addr][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_memory_hs.sv
// Randomised and directed bench for memory_hs.
// Three instances cover 8/16-bit data, partial depth and zero wait states.
module tb_memory_hs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req   [3];
  logic        we    [3];
  logic [4:0]  addr  [3];
  logic [1:0]  be    [3];
  logic [15:0] wdata [3];
  logic        ack   [3];
  logic        erro  [3];
  logic        busy  [3];
  logic [7:0]  rd_a, rd_c;
  logic [15:0] rd_b;
  logic [15:0] rdv [3];

  assign rdv[0] = {8'h00, rd_a};
  assign rdv[1] = rd_b;
  assign rdv[2] = {8'h00, rd_c};

  int DEP [3] = '{32, 24, 32};
  int WS  [3] = '{2, 3, 0};
  int NL  [3] = '{1, 2, 1};

  logic [15:0] mdl [3][32];
  logic [15:0] last_rd [3];
  int chk  = 0;
  int nerr = 0;

  memory_hs #(.AWIDTH(5), .DWIDTH(8), .DEPTH(32), .WAIT_STATES(2)) u_a (
    .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .be(be[0][0:0]), .wdata(wdata[0][7:0]), .rdata(rd_a),
    .ack(ack[0]), .err(erro[0]), .busy(busy[0]));

  memory_hs #(.AWIDTH(5), .DWIDTH(16), .DEPTH(24), .WAIT_STATES(3)) u_b (
    .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .be(be[1]), .wdata(wdata[1]), .rdata(rd_b),
    .ack(ack[1]), .err(erro[1]), .busy(busy[1]));

  memory_hs #(.AWIDTH(5), .DWIDTH(8), .DEPTH(32), .WAIT_STATES(0)) u_c (
    .clk(clk), .rst(rst), .req(req[2]), .we(we[2]), .addr(addr[2]),
    .be(be[2][0:0]), .wdata(wdata[2][7:0]), .rdata(rd_c),
    .ack(ack[2]), .err(erro[2]), .busy(busy[2]));

  task automatic access(input int d, input bit w, input logic [4:0] a,
                        input logic [1:0] b, input logic [15:0] wd,
                        input string nm);
    int lat;
    bit seen;
    bit inr;
    logic [15:0] exp_rd;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
    @(posedge clk);
    #1;
    req[d] = 1'b0; we[d] = 1'($urandom); addr[d] = 5'($urandom);
    be[d] = 2'($urandom); wdata[d] = 16'($urandom);
    inr = (int'(a) < DEP[d]);
    if (inr && w)
      for (int i = 0; i < NL[d]; i++)
        if (b[i]) mdl[d][a][8*i +: 8] = wd[8*i +: 8];
    if (inr && !w) last_rd[d] = mdl[d][a];
    exp_rd = last_rd[d];
    lat = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (ack[d] === 1'b1) seen = 1;
      else begin
        chk++;
        if (busy[d] !== 1'b1) begin
          nerr++;
          $display("FAIL %s busy_wait: got %b exp 1", nm, busy[d]);
        end
      end
    end
    chk++;
    if (lat !== WS[d] + 1) begin
      nerr++;
      $display("FAIL %s latency: got %0d exp %0d", nm, lat, WS[d] + 1);
    end
    chk++;
    if (erro[d] !== !inr) begin
      nerr++;
      $display("FAIL %s err: got %b exp %b", nm, erro[d], !inr);
    end
    chk++;
    if (rdv[d] !== exp_rd) begin
      nerr++;
      $display("FAIL %s rdata: got %h exp %h", nm, rdv[d], exp_rd);
    end
    chk++;
    if (busy[d] !== 1'b1) begin
      nerr++;
      $display("FAIL %s busy_ack: got %b exp 1", nm, busy[d]);
    end
    @(negedge clk);
    chk++;
    if ({ack[d], erro[d], busy[d]} !== 3'b000) begin
      nerr++;
      $display("FAIL %s after_ack: got ack/err/busy %b%b%b exp 000",
               nm, ack[d], erro[d], busy[d]);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      chk++;
      if ({rdv[d], ack[d], erro[d], busy[d]} !== 19'h0) begin
        nerr++;
        $display("FAIL reset d%0d: got rdata %h ack %b err %b busy %b exp 0",
                 d, rdv[d], ack[d], erro[d], busy[d]);
      end
    end
  endtask

  task automatic test_fill();
    for (int d = 0; d < 3; d++)
      for (int a = 0; a < 32; a++)
        access(d, 1'b1, 5'(a), 2'b11, 16'($urandom), "fill");
  endtask

  task automatic test_basic();
    access(0, 1'b1, 5'd3, 2'b01, 16'h00A5, "basic_wr");
    access(0, 1'b0, 5'd3, 2'b00, 16'h0000, "basic_rd");
    chk++;
    if (rdv[0] !== 16'h00A5) begin
      nerr++;
      $display("FAIL basic_value: got %h exp 00a5", rdv[0]);
    end
  endtask

  task automatic test_byte_lanes();
    access(1, 1'b1, 5'd5, 2'b11, 16'h1234, "lane_wr11");
    access(1, 1'b1, 5'd5, 2'b01, 16'hABCD, "lane_wr01");
    access(1, 1'b0, 5'd5, 2'b00, 16'h0000, "lane_rd");
    chk++;
    if (rdv[1] !== 16'h12CD) begin
      nerr++;
      $display("FAIL lane_value: got %h exp 12cd", rdv[1]);
    end
    access(1, 1'b1, 5'd5, 2'b00, 16'hFFFF, "lane_wr00");
    access(1, 1'b0, 5'd5, 2'b00, 16'h0000, "lane_rd2");
    chk++;
    if (rdv[1] !== 16'h12CD) begin
      nerr++;
      $display("FAIL lane_be0: got %h exp 12cd", rdv[1]);
    end
  endtask

  task automatic test_range();
    access(1, 1'b1, 5'd23, 2'b11, 16'h5A3C, "range_wr23");
    access(1, 1'b0, 5'd23, 2'b00, 16'h0000, "range_rd23");
    access(1, 1'b1, 5'd25, 2'b11, 16'h0077, "range_wr25");
    access(1, 1'b0, 5'd25, 2'b00, 16'h0000, "range_rd25");
    chk++;
    if (rdv[1] !== 16'h5A3C) begin
      nerr++;
      $display("FAIL range_hold: got %h exp 5a3c", rdv[1]);
    end
    access(1, 1'b0, 5'd0, 2'b00, 16'h0000, "range_rd0");
  endtask

  task automatic test_back_to_back();
    bit exp_ack;
    bit exp_busy;
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; be[0] = 2'b01;
    for (int k = 0; k < 12; k++) begin
      addr[0]  = 5'($urandom);
      wdata[0] = 16'($urandom_range(0, 255));
      if (k % 4 == 0) mdl[0][addr[0]][7:0] = wdata[0][7:0];
      @(negedge clk);
      exp_ack  = (k % 4 == 2);
      exp_busy = (k % 4 != 3);
      chk++;
      if (ack[0] !== exp_ack || erro[0] !== 1'b0) begin
        nerr++;
        $display("FAIL b2b_ack k%0d: got ack %b err %b exp ack %b err 0",
                 k, ack[0], erro[0], exp_ack);
      end
      chk++;
      if (busy[0] !== exp_busy) begin
        nerr++;
        $display("FAIL b2b_busy k%0d: got %b exp %b", k, busy[0], exp_busy);
      end
    end
    req[0] = 1'b0;
    for (int a = 0; a < 32; a++)
      access(0, 1'b0, 5'(a), 2'b00, 16'h0000, "b2b_readback");
  endtask

  task automatic test_reset_abort();
    access(0, 1'b1, 5'd7, 2'b01, 16'h0011, "abort_pre");
    access(0, 1'b0, 5'd7, 2'b00, 16'h0000, "abort_rd");
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 5'd7; be[0] = 2'b01;
    wdata[0] = 16'h0099;
    @(posedge clk);
    #1 req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk++;
    if ({rdv[0], ack[0], erro[0], busy[0]} !== 19'h0) begin
      nerr++;
      $display("FAIL abort_outputs: got rdata %h ack %b err %b busy %b exp 0",
               rdv[0], ack[0], erro[0], busy[0]);
    end
    for (int d = 0; d < 3; d++) last_rd[d] = 16'h0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk++;
      if (ack[0] !== 1'b0) begin
        nerr++;
        $display("FAIL abort_noack k%0d: got %b exp 0", k, ack[0]);
      end
    end
    access(0, 1'b0, 5'd7, 2'b00, 16'h0000, "abort_after");
    chk++;
    if (rdv[0] !== 16'h0011) begin
      nerr++;
      $display("FAIL abort_value: got %h exp 0011", rdv[0]);
    end
  endtask

  task automatic test_zero_wait();
    access(2, 1'b1, 5'd0, 2'b01, 16'h003C, "zw_wr0");
    access(2, 1'b1, 5'd31, 2'b01, 16'h00C3, "zw_wr31");
    access(2, 1'b0, 5'd0, 2'b00, 16'h0000, "zw_rd0");
    access(2, 1'b0, 5'd31, 2'b00, 16'h0000, "zw_rd31");
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++)
      access(n % 3, 1'($urandom), 5'($urandom), 2'($urandom),
             16'($urandom), "random");
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; be[d] = '0; wdata[d] = '0;
      last_rd[d] = 16'h0;
      for (int a = 0; a < 32; a++) mdl[d][a] = 16'h0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_fill();
    test_basic();
    test_byte_lanes();
    test_range();
    test_back_to_back();
    test_reset_abort();
    test_zero_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", chk, nerr);
    $finish;
  end

endmodule
